// File: rtl/wb8_interconnect_pkg.sv
// rtl/wb8_interconnect_pkg.sv - shared FSM encoding, defaults and width helpers for the 8-bit Wishbone interconnect
package wb8_interconnect_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_ERR  = 2'd2
  } state_e;

  localparam logic [7:0] WB8_ERR_DATA = 8'hFF;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb8_interconnect_if.sv
// rtl/wb8_interconnect_if.sv - master-side and steered slave-side signals of the 8-bit Wishbone interconnect
// Write data and WE fan out to the slaves directly and never pass through the interconnect.
interface wb8_interconnect_if #(
  parameter int NSLAVES = 4
) ();
  logic [31:0]          m_adr;
  logic                 m_cyc;
  logic                 m_stb;
  logic [7:0]           m_dat_r;
  logic                 m_ack;
  logic                 m_err;
  logic [NSLAVES-1:0]   s_stb;
  logic [8*NSLAVES-1:0] s_dat;
  logic [NSLAVES-1:0]   s_ack;

  modport master (
    output m_adr, m_cyc, m_stb, s_dat, s_ack,
    input  m_dat_r, m_ack, m_err, s_stb
  );

  modport slave (
    input  m_adr, m_cyc, m_stb, s_dat, s_ack,
    output m_dat_r, m_ack, m_err, s_stb
  );
endinterface

// File: rtl/wb8_interconnect_addr_decode.sv
// rtl/wb8_interconnect_addr_decode.sv - combinational base/mask window decoder, lowest matching index wins
module wb8_interconnect_addr_decode
  import wb8_interconnect_pkg::*;
#(
  parameter int NSLAVES = 4,
  localparam int SW = idx_width(NSLAVES)
) (
  input  logic [31:0]           adr_i,
  input  logic [32*NSLAVES-1:0] base_i,
  input  logic [32*NSLAVES-1:0] mask_i,
  output logic                  hit_o,
  output logic [SW-1:0]         idx_o
);

  // Scan from the top down so the lowest matching slot is the last to overwrite.
  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    for (int i = NSLAVES - 1; i >= 0; i--) begin
      if ((adr_i & mask_i[32*i +: 32]) == (base_i[32*i +: 32] & mask_i[32*i +: 32])) begin
        hit_o = 1'b1;
        idx_o = SW'(i);
      end
    end
  end

endmodule

// File: rtl/wb8_interconnect.sv
// rtl/wb8_interconnect.sv - single-master N-slave 8-bit Wishbone decoder/mux with bus watchdog and sticky error status
module wb8_interconnect
  import wb8_interconnect_pkg::*;
#(
  parameter int                  NSLAVES    = 4,
  parameter logic [32*NSLAVES-1:0] ADR_BASE = '0,
  parameter logic [32*NSLAVES-1:0] ADR_MASK = '0,
  parameter int                  TIMEOUT    = 255,
  parameter logic [7:0]          ERR_DATA   = WB8_ERR_DATA,
  parameter bit                  ERR_AS_ACK = 1'b1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               err_clear_i,
  output logic               err_flag_o,
  output logic [31:0]        err_adr_o,
  wb8_interconnect_if.slave  bus
);

  localparam int SW = idx_width(NSLAVES);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] FIRE_AT = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_e        state_q, state_d;
  logic [SW-1:0] sel_q, sel_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_flag_q, err_flag_d;
  logic [31:0]   err_adr_q, err_adr_d;

  logic               req;
  logic               dec_hit;
  logic [SW-1:0]      dec_idx;
  logic               wdog_fire;
  logic [NSLAVES-1:0] stb_c;
  logic               ack_c;
  logic               err_c;
  logic [7:0]         dat_c;

  wb8_interconnect_addr_decode #(
    .NSLAVES (NSLAVES)
  ) u_decode (
    .adr_i  (bus.m_adr),
    .base_i (ADR_BASE),
    .mask_i (ADR_MASK),
    .hit_o  (dec_hit),
    .idx_o  (dec_idx)
  );

  assign req = bus.m_cyc & bus.m_stb;
  // The issue cycle in IDLE is the first stalled cycle, so BUSY fires at TIMEOUT-1.
  assign wdog_fire = (TIMEOUT != 0) && (cnt_q >= FIRE_AT);

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    cnt_d      = cnt_q;
    err_flag_d = err_flag_q & ~err_clear_i;
    err_adr_d  = err_adr_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          if (dec_hit) begin
            sel_d = dec_idx;
            cnt_d = '0;
            if (!bus.s_ack[dec_idx]) state_d = ST_BUSY;
          end else begin
            state_d = ST_ERR;
          end
        end
      end
      ST_BUSY: begin
        if (!req) begin
          state_d = ST_IDLE;
        end else if (wdog_fire) begin
          state_d = ST_ERR;
        end else if (bus.s_ack[sel_q]) begin
          state_d = ST_IDLE;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_ERR: begin
        err_flag_d = 1'b1;
        err_adr_d  = bus.m_adr;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    stb_c = '0;
    if (!rst_i) begin
      case (state_q)
        ST_IDLE: if (req && dec_hit) stb_c[dec_idx] = 1'b1;
        ST_BUSY: if (req && !wdog_fire) stb_c[sel_q] = 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    ack_c = 1'b0;
    err_c = 1'b0;
    dat_c = ERR_DATA;
    if (!rst_i) begin
      case (state_q)
        ST_IDLE: begin
          if (req && dec_hit) begin
            dat_c = bus.s_dat[8*dec_idx +: 8];
            ack_c = bus.s_ack[dec_idx];
          end
        end
        ST_BUSY: begin
          dat_c = bus.s_dat[8*sel_q +: 8];
          ack_c = req && !wdog_fire && bus.s_ack[sel_q];
        end
        ST_ERR: begin
          err_c = 1'b1;
          ack_c = ERR_AS_ACK;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      sel_q      <= '0;
      cnt_q      <= '0;
      err_flag_q <= 1'b0;
      err_adr_q  <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      cnt_q      <= cnt_d;
      err_flag_q <= err_flag_d;
      err_adr_q  <= err_adr_d;
    end
  end

  assign bus.s_stb   = stb_c;
  assign bus.m_ack   = ack_c;
  assign bus.m_err   = err_c;
  assign bus.m_dat_r = dat_c;
  assign err_flag_o  = err_flag_q;
  assign err_adr_o   = err_adr_q;

endmodule
